misaligned_load_merger: RTL and testbench
=========================================

Name: misaligned_load_merger

Overview:
- Read-side counterpart to the bank-offset logic on the store/address path: sequences loads from a single-ported, word-wide data memory and returns the aligned result to the core.
- Splits any load that crosses a word boundary into two consecutive word reads.
- Merges the two words, extracts the byte/half/word and sign- or zero-extends per RV32 funct3.
- Sits between the core's memory stage (request/response) and the data RAM read port.

Parameters:
- ADDR_W, 10, word-address width of the data RAM; byte address bits [ADDR_W+1:2] form the word address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  32  byte address of the load.
- req_funct3  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011/110/111 treated as lw.
- mem_re  output  1  RAM read enable; data returns on mem_rdata one cycle later.
- mem_addr  output  ADDR_W  RAM word address.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_re.
- rsp_valid  output  1  one-cycle pulse, rsp_data valid.
- rsp_data  output  32  aligned, extended load result.
- rsp_split  output  1  high with rsp_valid when two reads were used.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_split=0; internal latches cleared; req_ready=1.
- req_ready = (state==IDLE), decoded from state. A request is accepted on a clk edge with req_valid&&req_ready; latch addr[1:0], word address, funct3, and the split flag.
- Split flag: lw/illegal with addr[1:0]!=0; lh/lhu with addr[1:0]==3; never for lb/lbu.
- States (mem_re, mem_addr, rsp_valid, rsp_split registered; values apply during the named state):
  - IDLE: mem_re=0. Accept -> RD_LO.
  - RD_LO: mem_re=1, mem_addr=word. Next: split ? RD_HI : WAIT.
  - RD_HI: mem_re=1, mem_addr=word+1 (mod 2^ADDR_W, wraps to 0). Capture mem_rdata as lo. -> WAIT.
  - WAIT: mem_re=0. Capture mem_rdata (hi if split, else lo). Compute result and register into rsp_data. -> RESP.
  - RESP: rsp_valid=1, rsp_split=split flag. -> IDLE.
- Latency: accept edge T; rsp_valid high in cycle T+3 (aligned) or T+4 (split). Max throughput: 1 load per 4 (aligned) or 5 (split) cycles.
- Merge: form the 64-bit value {hi,lo} (hi=0 when not split) and shift right by 8*addr[1:0].
  - lb/lbu take bits [7:0]; lh/lhu take [15:0]; lw takes [31:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- rsp_data holds its value after RESP until the next WAIT. rsp_split=0 outside RESP.
- There is no response backpressure: the core must sample rsp_data during the rsp_valid cycle.
- req_valid outside IDLE is ignored; the core holds the request until req_ready.
- req_addr bits above ADDR_W+1 are ignored.
- rst_n asserted mid-operation: the operation is abandoned immediately, mem_re drops asynchronously, and no rsp_valid is produced for that request.

Test Plan:
- RAM word0=0x44332211, word1=0x88776685. lw addr 0x0 accepted at T -> mem_re in T+1 only, mem_addr=0; rsp_valid at T+3, rsp_data=0x44332211, rsp_split=0.
- lw addr 0x1 -> mem_addr 0 in T+1 and 1 in T+2; rsp_valid at T+4, rsp_data=0x85443322, rsp_split=1.
- lh addr 0x3 -> split, rsp_data=0xFFFF8544; lhu addr 0x3 -> 0x00008544. lh addr 0x2 -> not split, rsp_data=0x00004433.
- lb addr 0x7 -> 0xFFFFFF88; lbu addr 0x6 -> 0x00000077; funct3=011 addr 0x0 -> 0x44332211, treated as lw.
- ADDR_W=4, lw addr 0x3E -> mem_addr 15 then 0 (wrap), rsp_split=1. req_valid held during busy -> no second accept until the cycle after RESP.
- rst_n low during RD_HI -> mem_re=0 at once; after release req_ready=1, no rsp_valid seen; next lw addr 0 completes normally.

Source files
------------

// File: rtl/misaligned_load_merger.sv
// Load sequencer between the core memory stage and a single-ported word RAM.
// Word-crossing loads take two reads; the words are merged, aligned and extended.
module misaligned_load_merger #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_split
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [2:0]        f3_q, f3_d;
  logic              split_q, split_d;
  logic [31:0]       lo_q, lo_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_split_q, rsp_split_d;

  logic              split_req;
  logic [63:0]       merged;
  logic [63:0]       merged_sh;
  logic [31:0]       result;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // A load crosses a word only when its last byte lands past byte 3.
  always_comb begin
    split_req = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: split_req = 1'b0;
      3'b001, 3'b101: split_req = (req_addr[1:0] == 2'd3);
      default:        split_req = (req_addr[1:0] != 2'd0);
    endcase
  end

  always_comb begin
    merged    = split_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
    merged_sh = merged >> {off_q, 3'b000};
    result    = merged_sh[31:0];
    case (f3_q)
      3'b000:  result = {{24{merged_sh[7]}}, merged_sh[7:0]};
      3'b100:  result = {24'h0, merged_sh[7:0]};
      3'b001:  result = {{16{merged_sh[15]}}, merged_sh[15:0]};
      3'b101:  result = {16'h0, merged_sh[15:0]};
      default: result = merged_sh[31:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    word_d     = word_q;
    f3_d       = f3_q;
    split_d    = split_q;
    lo_d       = lo_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_RD_LO;
          off_d      = req_addr[1:0];
          word_d     = req_addr[ADDR_W+1:2];
          f3_d       = req_funct3;
          split_d    = split_req;
          mem_addr_d = req_addr[ADDR_W+1:2];
        end
      end
      S_RD_LO: begin
        if (split_q) begin
          state_d    = S_RD_HI;
          mem_addr_d = word_q + 1'b1;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_RD_HI: begin
        lo_d    = mem_rdata;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        rsp_data_d = result;
        state_d    = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    mem_re_d    = (state_d == S_RD_LO) || (state_d == S_RD_HI);
    rsp_valid_d = (state_d == S_RESP);
    rsp_split_d = (state_d == S_RESP) && split_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      word_q      <= '0;
      f3_q        <= '0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_split_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      word_q      <= word_d;
      f3_q        <= f3_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_split_q <= rsp_split_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_split = rsp_split_q;

endmodule

// File: tb/tb_misaligned_load_merger.sv
// Bench for misaligned_load_merger: directed vectors plus randomized loads
// checked against a byte-level model of a 16-word RAM.
module tb_misaligned_load_merger;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [2:0]    req_funct3 = '0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_split;

  logic [31:0]   ram [16];
  int            n_checks = 0;
  int            n_pass = 0;

  misaligned_load_merger #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_split(rsp_split)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

  // Reference: gather the addressed bytes from a 64-byte wrapping space.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3,
                                             output logic split);
    int n, base, ba;
    logic [31:0] v;
    logic [7:0]  b;
    n    = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    base = int'(a[5:0]);
    v    = '0;
    for (int i = 0; i < n; i++) begin
      ba = (base + i) % 64;
      b  = ram[ba / 4][(ba % 4) * 8 +: 8];
      v  = v | (32'(b) << (8 * i));
    end
    split = ((base % 4) + n) > 4;
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                         output logic [31:0] d, output logic s, output int lat,
                         output int nre, output logic [AW-1:0] a0, output logic [AW-1:0] a1);
    int k;
    d = '0; s = 1'b0; lat = -1; nre = 0; a0 = '0; a1 = '0; k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_addr = a; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_re) begin
        if (nre == 0) a0 = mem_addr; else a1 = mem_addr;
        nre++;
      end
      if (rsp_valid) begin d = rsp_data; s = rsp_split; lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset req_ready got %b exp 1", req_ready); else n_pass++;
    n_checks++; if (mem_re !== 1'b0) $display("FAIL reset mem_re got %b exp 0", mem_re); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL reset mem_addr got %h exp 0", mem_addr); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset rsp_data got %h exp 0", rsp_data); else n_pass++;
    n_checks++; if (rsp_split !== 1'b0) $display("FAIL reset rsp_split got %b exp 0", rsp_split); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'h0, 32'h1, 32'h3, 32'h3, 32'h2, 32'h7, 32'h6, 32'h0};
    logic [2:0]  tf [8] = '{3'd2, 3'd2, 3'd1, 3'd5, 3'd1, 3'd0, 3'd4, 3'd3};
    logic [31:0] td [8] = '{32'h44332211, 32'h85443322, 32'hFFFF8544, 32'h00008544,
                            32'h00004433, 32'hFFFFFF88, 32'h00000077, 32'h44332211};
    logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] d; logic s; int lat, nre; logic [AW-1:0] a0, a1;
    ram[0] = 32'h44332211; ram[1] = 32'h88776685;
    for (int i = 0; i < 8; i++) begin
      do_load(ta[i], tf[i], d, s, lat, nre, a0, a1);
      n_checks++; if (d !== td[i]) $display("FAIL dir%0d data got %h exp %h", i, d, td[i]); else n_pass++;
      n_checks++; if (s !== ts[i]) $display("FAIL dir%0d split got %b exp %b", i, s, ts[i]); else n_pass++;
      n_checks++; if (lat !== (ts[i] ? 4 : 3)) $display("FAIL dir%0d latency got %0d exp %0d", i, lat, ts[i] ? 4 : 3); else n_pass++;
      if (i == 0) begin
        n_checks++; if (nre !== 1 || a0 !== 4'd0) $display("FAIL dir0 reads got n=%0d a0=%0d exp n=1 a0=0", nre, a0); else n_pass++;
      end
      if (i == 1) begin
        n_checks++; if (nre !== 2 || a0 !== 4'd0 || a1 !== 4'd1) $display("FAIL dir1 reads got n=%0d a0=%0d a1=%0d exp 2/0/1", nre, a0, a1); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic s; int lat, nre; logic [AW-1:0] a0, a1;
    ram[15] = 32'hDDCCBBAA;
    do_load(32'h3E, 3'd2, d, s, lat, nre, a0, a1);
    n_checks++; if (a0 !== 4'd15 || a1 !== 4'd0 || nre !== 2) $display("FAIL wrap addrs got %0d,%0d n=%0d exp 15,0 n=2", a0, a1, nre); else n_pass++;
    n_checks++; if (s !== 1'b1) $display("FAIL wrap split got %b exp 1", s); else n_pass++;
    n_checks++; if (d !== 32'h2211DDCC) $display("FAIL wrap data got %h exp 2211ddcc", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic rdy [5]; logic rv [5];
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; req_funct3 = 3'd2;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); rdy[i] = req_ready; rv[i] = rsp_valid;
    end
    @(posedge clk); #1; req_valid = 1'b0;
    n_checks++; if ({rdy[1], rdy[2], rdy[3], rdy[4]} !== 4'b0001) $display("FAIL b2b ready got %b%b%b%b exp 0001", rdy[1], rdy[2], rdy[3], rdy[4]); else n_pass++;
    n_checks++; if ({rv[1], rv[2], rv[3], rv[4]} !== 4'b0010) $display("FAIL b2b rsp_valid got %b%b%b%b exp 0010", rv[1], rv[2], rv[3], rv[4]); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b1 || req_ready !== 1'b0) $display("FAIL b2b second accept mem_re=%b ready=%b exp 1/0", mem_re, req_ready); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [31:0] d; logic s; int lat, nre; logic [AW-1:0] a0, a1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1; req_funct3 = 3'd2;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 4'd1) $display("FAIL rstmid rd_hi mem_re=%b addr=%0d exp 1/1", mem_re, mem_addr); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_re !== 1'b0) $display("FAIL rstmid mem_re got %b exp 0", mem_re); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rstmid req_ready got %b exp 1", req_ready); else n_pass++;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL rstmid rsp_valid pulses got %0d exp 0", seen); else n_pass++;
    do_load(32'h0, 3'd2, d, s, lat, nre, a0, a1);
    n_checks++; if (d !== 32'h44332211 || lat !== 3) $display("FAIL rstmid after data=%h lat=%0d exp 44332211/3", d, lat); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed; logic [2:0] f3; logic s, es; int lat, nre; logic [AW-1:0] a0, a1;
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      ed = model_load(a, f3, es);
      do_load(a, f3, d, s, lat, nre, a0, a1);
      n_checks++; if (d !== ed) $display("FAIL rnd%0d data a=%h f3=%0d got %h exp %h", i, a, f3, d, ed); else n_pass++;
      n_checks++; if (s !== es) $display("FAIL rnd%0d split a=%h f3=%0d got %b exp %b", i, a, f3, s, es); else n_pass++;
      n_checks++; if (lat !== (es ? 4 : 3) || nre !== (es ? 2 : 1)) $display("FAIL rnd%0d timing lat=%0d reads=%0d exp split=%b", i, lat, nre, es); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
